// File: rtl/bp_be_stride_detector_if.sv
// Load-stream, iteration-count and prefetch-descriptor signals of the stride detector.
// slave is the detector side, master is the environment driving it.
interface bp_be_stride_detector_if #(
  parameter int unsigned vaddr_width_p  = 39,
  parameter int unsigned stride_width_p = 16,
  parameter int unsigned output_range_p = 8
) ();
  logic                      ld_v_i;
  logic [vaddr_width_p-1:0]  ld_pc_i;
  logic [vaddr_width_p-1:0]  ld_vaddr_i;
  logic                      start_discovery_o;
  logic                      confirm_discovery_o;
  logic [vaddr_width_p-1:0]  striding_pc_o;
  logic                      iter_v_i;
  logic [output_range_p-1:0] iter_count_i;
  logic                      iter_yumi_o;
  logic                      pf_v_o;
  logic                      pf_ready_i;
  logic [vaddr_width_p-1:0]  pf_pc_o;
  logic [vaddr_width_p-1:0]  pf_base_o;
  logic [stride_width_p-1:0] pf_stride_o;
  logic [output_range_p-1:0] pf_count_o;

  modport slave (
    input  ld_v_i, ld_pc_i, ld_vaddr_i, iter_v_i, iter_count_i, pf_ready_i,
    output start_discovery_o, confirm_discovery_o, striding_pc_o, iter_yumi_o,
           pf_v_o, pf_pc_o, pf_base_o, pf_stride_o, pf_count_o
  );

  modport master (
    output ld_v_i, ld_pc_i, ld_vaddr_i, iter_v_i, iter_count_i, pf_ready_i,
    input  start_discovery_o, confirm_discovery_o, striding_pc_o, iter_yumi_o,
           pf_v_o, pf_pc_o, pf_base_o, pf_stride_o, pf_count_o
  );
endinterface

// File: rtl/bp_be_stride_detector.sv
// Per-PC constant-stride learner feeding loop-iteration inference, then emitting
// one prefetch descriptor per confirmed stream.
module bp_be_stride_detector #(
  parameter int unsigned vaddr_width_p    = 39,
  parameter int unsigned entries_p        = 4,
  parameter int unsigned stride_width_p   = 16,
  parameter int unsigned start_thresh_p   = 1,
  parameter int unsigned confirm_thresh_p = 3,
  parameter int unsigned output_range_p   = 8
) (
  input logic                     clk_i,
  input logic                     reset_n_i,
  bp_be_stride_detector_if.slave  io
);

  localparam int unsigned idx_w_lp = (entries_p > 1) ? $clog2(entries_p) : 1;
  localparam int unsigned ext_w_lp = vaddr_width_p - stride_width_p;

  typedef enum logic [1:0] {
    e_idle,
    e_discover,
    e_confirmed,
    e_emit
  } state_e;

  logic [entries_p-1:0]      v_q;
  logic [vaddr_width_p-1:0]  pc_q     [entries_p];
  logic [vaddr_width_p-1:0]  last_q   [entries_p];
  logic [stride_width_p-1:0] stride_q [entries_p];
  logic [1:0]                conf_q   [entries_p];
  logic [idx_w_lp-1:0]       rr_q;

  state_e                    state_q;
  logic [idx_w_lp-1:0]       track_q;
  logic                      start_q, confirm_q, pf_v_q;
  logic [vaddr_width_p-1:0]  striding_pc_q, pf_pc_q, pf_base_q;
  logic [stride_width_p-1:0] pf_stride_q;
  logic [output_range_p-1:0] pf_count_q;

  logic                      hit;
  logic [idx_w_lp-1:0]       hit_idx;
  logic [vaddr_width_p-1:0]  delta, hit_stride_ext, trk_stride_ext;
  logic                      delta_fits, same_stride;
  logic [1:0]                hit_conf_d;
  logic [stride_width_p-1:0] hit_stride_d;
  logic                      track_hit, track_evict;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < entries_p; i++) begin
      if (!hit && v_q[i] && (pc_q[i] == io.ld_pc_i)) begin
        hit     = 1'b1;
        hit_idx = idx_w_lp'(i);
      end
    end
  end

  // A delta fits the stride field when every bit above it repeats its sign bit.
  always_comb begin
    delta          = io.ld_vaddr_i - last_q[hit_idx];
    hit_stride_ext = {{ext_w_lp{stride_q[hit_idx][stride_width_p-1]}}, stride_q[hit_idx]};
    trk_stride_ext = {{ext_w_lp{stride_q[track_q][stride_width_p-1]}}, stride_q[track_q]};
    delta_fits     = (&delta[vaddr_width_p-1:stride_width_p-1])
                   | ~(|delta[vaddr_width_p-1:stride_width_p-1]);
    same_stride    = delta_fits && (delta != '0) && (delta == hit_stride_ext);
    hit_stride_d   = delta_fits ? delta[stride_width_p-1:0] : '0;
    hit_conf_d     = '0;
    if (same_stride) begin
      hit_conf_d = (conf_q[hit_idx] == 2'd3) ? 2'd3 : conf_q[hit_idx] + 2'd1;
    end
  end

  assign track_hit   = io.ld_v_i && hit && (hit_idx == track_q);
  assign track_evict = io.ld_v_i && !hit && (rr_q == track_q);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q  <= '0;
      rr_q <= '0;
      for (int unsigned i = 0; i < entries_p; i++) begin
        pc_q[i]     <= '0;
        last_q[i]   <= '0;
        stride_q[i] <= '0;
        conf_q[i]   <= '0;
      end
    end else if (io.ld_v_i) begin
      if (hit) begin
        last_q[hit_idx] <= io.ld_vaddr_i;
        conf_q[hit_idx] <= hit_conf_d;
        if (!same_stride) begin
          stride_q[hit_idx] <= hit_stride_d;
        end
      end else begin
        v_q[rr_q]      <= 1'b1;
        pc_q[rr_q]     <= io.ld_pc_i;
        last_q[rr_q]   <= io.ld_vaddr_i;
        stride_q[rr_q] <= '0;
        conf_q[rr_q]   <= '0;
        rr_q           <= rr_q + idx_w_lp'(1);
      end
    end
  end

  // Qualification reads the pre-update table, so a load coinciding with a
  // transition is judged against the state it arrived in.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= e_idle;
      track_q       <= '0;
      start_q       <= 1'b0;
      confirm_q     <= 1'b0;
      striding_pc_q <= '0;
      pf_v_q        <= 1'b0;
      pf_pc_q       <= '0;
      pf_base_q     <= '0;
      pf_stride_q   <= '0;
      pf_count_q    <= '0;
    end else begin
      start_q   <= 1'b0;
      confirm_q <= 1'b0;
      unique case (state_q)
        e_idle: begin
          if (io.ld_v_i && hit && (hit_conf_d == 2'(start_thresh_p))) begin
            state_q       <= e_discover;
            start_q       <= 1'b1;
            striding_pc_q <= io.ld_pc_i;
            track_q       <= hit_idx;
          end
        end
        e_discover: begin
          if (track_hit && (hit_conf_d == 2'(confirm_thresh_p))) begin
            state_q   <= e_confirmed;
            confirm_q <= 1'b1;
          end else if ((track_hit && (hit_conf_d == 2'd0)) || track_evict) begin
            state_q <= e_idle;
          end
        end
        e_confirmed: begin
          if (io.iter_v_i) begin
            if (io.iter_count_i == '0) begin
              state_q <= e_idle;
            end else begin
              state_q     <= e_emit;
              pf_v_q      <= 1'b1;
              pf_pc_q     <= striding_pc_q;
              pf_base_q   <= last_q[track_q] + trk_stride_ext;
              pf_stride_q <= stride_q[track_q];
              pf_count_q  <= io.iter_count_i;
            end
          end
        end
        e_emit: begin
          if (io.pf_ready_i) begin
            state_q <= e_idle;
            pf_v_q  <= 1'b0;
          end
        end
        default: state_q <= e_idle;
      endcase
    end
  end

  assign io.start_discovery_o   = start_q;
  assign io.confirm_discovery_o = confirm_q;
  assign io.striding_pc_o       = striding_pc_q;
  assign io.iter_yumi_o         = (state_q == e_confirmed) && io.iter_v_i;
  assign io.pf_v_o              = pf_v_q;
  assign io.pf_pc_o             = pf_pc_q;
  assign io.pf_base_o           = pf_base_q;
  assign io.pf_stride_o         = pf_stride_q;
  assign io.pf_count_o          = pf_count_q;

endmodule
